// File: rtl/optical_link_monitor_pkg.sv
// optical_link_monitor_pkg
//   Shared definitions for the multi-channel optical link monitor.
//   - link_state_t : per-channel lock/health FSM encoding (2 bits)
//   - MARKER_DEFAULT : kchar value that marks the latency frame
//   - DELAY_DEPTH : number of taps in each channel's programmable delay line
package optical_link_monitor_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    GOOD  = 2'd2,
    BAD   = 2'd3
  } link_state_t;

  localparam logic [15:0] MARKER_DEFAULT = 16'h50FC;
  localparam int          DELAY_DEPTH    = 16;

endpackage

// File: rtl/optical_link_monitor_ch.sv
// optical_link_monitor_ch
//   One fiber channel: K-char marker phase checking, lock/health FSM,
//   saturating error counter and a 1..16 bx masked delay line.
// Ports
//   clock, reset          fabric clock, sync active-high reset
//   ttc_resync            sync; clears link state, keeps delay setting and delay line
//   err_cnt_clr           clears err_count only
//   delay [3:0]           extra delay in bx (total latency 1+delay)
//   din [DW-1:0]          recovered data frame
//   kin [KW-1:0]          recovered kchar
//   dout, kout            delayed, masked frame
//   link_good, link_bad   registered FSM state flags
//   link_had_err          sticky marker-error flag
//   err_pulse             1-cycle pulse per marker error
//   err_count [ECW-1:0]   saturating marker-error count
module optical_link_monitor_ch
  import optical_link_monitor_pkg::*;
#(
  parameter int              DW       = 48,
  parameter int              KW       = 16,
  parameter logic [KW-1:0]   MARKER   = KW'(MARKER_DEFAULT),
  parameter int              PERIOD   = 128,
  parameter int              GOOD_N   = 4,
  parameter int              BAD_N    = 3,
  parameter int              ECW      = 16,
  parameter int              MASK_BAD = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ttc_resync,
  input  logic           err_cnt_clr,
  input  logic [3:0]     delay,
  input  logic [DW-1:0]  din,
  input  logic [KW-1:0]  kin,
  output logic [DW-1:0]  dout,
  output logic [KW-1:0]  kout,
  output logic           link_good,
  output logic           link_bad,
  output logic           link_had_err,
  output logic           err_pulse,
  output logic [ECW-1:0] err_count
);

  localparam int CW  = $clog2(PERIOD);
  localparam int GRW = $clog2(GOOD_N + 1);
  localparam int BRW = $clog2(BAD_N + 1);
  localparam int FW  = DW + KW;

  link_state_t    state, state_next;
  logic [CW-1:0]  phase_cnt;
  logic           slot_due;
  logic           miss_pending;
  logic [GRW-1:0] good_run, good_run_next;
  logic [BRW-1:0] bad_run, bad_run_next;
  logic [3:0]     delay_q;
  logic [FW-1:0]  delay_line [DELAY_DEPTH];
  logic [FW-1:0]  frame_in;

  logic marker;
  logic hunting;
  logic late_marker;
  logic marker_err;
  logic on_time;

  // slot_due is the registered form of "counter at PERIOD-1", so it is high
  // in the bx that is exactly PERIOD after the last marker.
  // A missing marker raises miss_pending; the first off-slot marker that
  // follows is the same late marker and only re-phases without a second error.
  assign marker      = (kin == MARKER);
  assign hunting     = (state == HUNT);
  assign late_marker = marker && !slot_due && miss_pending;
  assign marker_err  = !hunting && (marker != slot_due) && !late_marker;
  assign on_time     = !hunting && marker && slot_due;

  always_comb begin
    state_next    = state;
    good_run_next = good_run;
    bad_run_next  = bad_run;
    case (state)
      HUNT: begin
        if (marker) begin
          good_run_next = GRW'(1);
          bad_run_next  = '0;
          state_next    = (GOOD_N <= 1) ? GOOD : CHECK;
        end
      end
      CHECK: begin
        if (marker_err) begin
          good_run_next = '0;
          state_next    = HUNT;
        end else if (on_time) begin
          good_run_next = good_run + GRW'(1);
          if (good_run == GRW'(GOOD_N - 1)) begin
            bad_run_next = '0;
            state_next   = GOOD;
          end
        end
      end
      GOOD: begin
        if (marker_err) begin
          bad_run_next = bad_run + BRW'(1);
          if (bad_run == BRW'(BAD_N - 1)) begin
            state_next = BAD;
          end
        end else if (on_time) begin
          bad_run_next = '0;
        end
      end
      BAD: begin
        state_next = BAD;
      end
      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || ttc_resync) begin
      state        <= HUNT;
      good_run     <= '0;
      bad_run      <= '0;
      phase_cnt    <= '0;
      slot_due     <= 1'b0;
      miss_pending <= 1'b0;
      link_good    <= 1'b0;
      link_bad     <= 1'b0;
      link_had_err <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_next;
      good_run     <= good_run_next;
      bad_run      <= bad_run_next;
      phase_cnt    <= marker ? CW'(1) : phase_cnt + CW'(1);
      slot_due     <= !marker && (phase_cnt == CW'(PERIOD - 1));
      link_good    <= (state_next == GOOD);
      link_bad     <= (state_next == BAD);
      link_had_err <= link_had_err | marker_err;
      err_pulse    <= marker_err;

      if (hunting) begin
        miss_pending <= 1'b0;
      end else if (slot_due) begin
        miss_pending <= !marker;
      end else if (marker) begin
        miss_pending <= 1'b0;
      end

      if (err_cnt_clr) begin
        err_count <= marker_err ? ECW'(1) : '0;
      end else if (marker_err && (err_count != {ECW{1'b1}})) begin
        err_count <= err_count + ECW'(1);
      end
    end
  end

  // Masking looks at link_good as registered now, i.e. the health of the
  // link at the moment this frame is captured, not when it leaves the line.
  assign frame_in = ((MASK_BAD == 0) || link_good) ? {kin, din} : '0;

  // Delay line is untouched by ttc_resync so frames in flight still emerge.
  always_ff @(posedge clock) begin
    if (reset) begin
      delay_q <= '0;
      for (int i = 0; i < DELAY_DEPTH; i++) begin
        delay_line[i] <= '0;
      end
    end else begin
      delay_q       <= delay;
      delay_line[0] <= frame_in;
      for (int i = 1; i < DELAY_DEPTH; i++) begin
        delay_line[i] <= delay_line[i-1];
      end
    end
  end

  assign {kout, dout} = delay_line[delay_q];

endmodule

// File: rtl/optical_link_monitor.sv
// optical_link_monitor
//   NCH-channel receive monitor for DCFEB optical frames. Each channel is an
//   independent optical_link_monitor_ch; this level only slices the buses.
// Ports
//   clock, reset, ttc_resync   fabric clock, sync reset, sync resync
//   err_cnt_clr [NCH]          per-channel err_count clear
//   delay [4*NCH]              per-channel delay, ch i = [4i+3:4i]
//   din [DW*NCH], kin [KW*NCH] per-channel recovered frames
//   dout, kout                 delayed, masked frames
//   link_good, link_bad, link_had_err, err_pulse [NCH]
//   err_count [ECW*NCH]        per-channel saturating error counts
module optical_link_monitor
  import optical_link_monitor_pkg::*;
#(
  parameter int            NCH      = 7,
  parameter int            DW       = 48,
  parameter int            KW       = 16,
  parameter logic [KW-1:0] MARKER   = KW'(MARKER_DEFAULT),
  parameter int            PERIOD   = 128,
  parameter int            GOOD_N   = 4,
  parameter int            BAD_N    = 3,
  parameter int            ECW      = 16,
  parameter int            MASK_BAD = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ttc_resync,
  input  logic [NCH-1:0]     err_cnt_clr,
  input  logic [4*NCH-1:0]   delay,
  input  logic [DW*NCH-1:0]  din,
  input  logic [KW*NCH-1:0]  kin,
  output logic [DW*NCH-1:0]  dout,
  output logic [KW*NCH-1:0]  kout,
  output logic [NCH-1:0]     link_good,
  output logic [NCH-1:0]     link_bad,
  output logic [NCH-1:0]     link_had_err,
  output logic [NCH-1:0]     err_pulse,
  output logic [ECW*NCH-1:0] err_count
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    optical_link_monitor_ch #(
      .DW       (DW),
      .KW       (KW),
      .MARKER   (MARKER),
      .PERIOD   (PERIOD),
      .GOOD_N   (GOOD_N),
      .BAD_N    (BAD_N),
      .ECW      (ECW),
      .MASK_BAD (MASK_BAD)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .ttc_resync   (ttc_resync),
      .err_cnt_clr  (err_cnt_clr[i]),
      .delay        (delay[4*i +: 4]),
      .din          (din[DW*i +: DW]),
      .kin          (kin[KW*i +: KW]),
      .dout         (dout[DW*i +: DW]),
      .kout         (kout[KW*i +: KW]),
      .link_good    (link_good[i]),
      .link_bad     (link_bad[i]),
      .link_had_err (link_had_err[i]),
      .err_pulse    (err_pulse[i]),
      .err_count    (err_count[ECW*i +: ECW])
    );
  end

endmodule

// File: tb/tb_optical_link_monitor.sv
// tb_optical_link_monitor
//   Directed bench for optical_link_monitor: lock, marker shift, dropped
//   markers, delay line, error counter saturation/clear and ttc_resync.
//   Channel c sends a marker every 128 bx at phase 7*c; data is a ramp that
//   encodes channel and bx so delayed frames can be identified.
module tb_optical_link_monitor;

  localparam int NCH    = 7;
  localparam int DW     = 48;
  localparam int KW     = 16;
  localparam int ECW    = 16;
  localparam int PERIOD = 128;
  localparam logic [KW-1:0] MARKER = 16'h50FC;
  localparam logic [KW-1:0] IDLE_K = 16'h00BC;

  logic               clock;
  logic               reset;
  logic               ttc_resync;
  logic [NCH-1:0]     err_cnt_clr;
  logic [4*NCH-1:0]   delay;
  logic [DW*NCH-1:0]  din;
  logic [KW*NCH-1:0]  kin;
  logic [DW*NCH-1:0]  dout;
  logic [KW*NCH-1:0]  kout;
  logic [NCH-1:0]     link_good;
  logic [NCH-1:0]     link_bad;
  logic [NCH-1:0]     link_had_err;
  logic [NCH-1:0]     err_pulse;
  logic [ECW*NCH-1:0] err_count;

  int checks;
  int errors;
  int bx;
  int ph   [NCH];
  bit on   [NCH];
  int drop [NCH];
  bit cont [NCH];
  logic [3:0] dly [NCH];

  optical_link_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .ttc_resync   (ttc_resync),
    .err_cnt_clr  (err_cnt_clr),
    .delay        (delay),
    .din          (din),
    .kin          (kin),
    .dout         (dout),
    .kout         (kout),
    .link_good    (link_good),
    .link_bad     (link_bad),
    .link_had_err (link_had_err),
    .err_pulse    (err_pulse),
    .err_count    (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at bx %0d", bx);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] din_val(input int c, input int n);
    logic [7:0]  cb;
    logic [31:0] nb;
    cb = c[7:0];
    nb = n;
    return {cb, 8'hA5, nb};
  endfunction

  // Drive one bx of inputs, clock it in, and land 1 time unit after the edge.
  task automatic step();
    for (int c = 0; c < NCH; c++) begin
      logic mk;
      mk = 1'b0;
      if (cont[c]) begin
        mk = 1'b1;
      end else if (on[c] && bx >= ph[c] && ((bx - ph[c]) % PERIOD) == 0) begin
        if (drop[c] > 0) drop[c] = drop[c] - 1;
        else mk = 1'b1;
      end
      kin[c*KW +: KW]  = mk ? MARKER : IDLE_K;
      din[c*DW +: DW]  = din_val(c, bx);
      delay[c*4 +: 4]  = dly[c];
    end
    @(posedge clock);
    #1;
    bx = bx + 1;
  endtask

  // After run_to(n) the last bx clocked in is n.
  task automatic run_to(input int n);
    while (bx <= n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (dout !== '0 || kout !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: dout=%h kout=%h required 0", dout, kout);
    end
    checks++;
    if ({link_good, link_bad, link_had_err, err_pulse} !== '0 || err_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_flags: good=%b bad=%b had=%b pulse=%b cnt=%h required all 0",
               link_good, link_bad, link_had_err, err_pulse, err_count);
    end
    reset = 1'b0;
    bx = 0;
    for (int c = 0; c < NCH; c++) on[c] = 1'b1;
  endtask

  task automatic test_lock();
    run_to(383);
    checks++;
    if (link_good !== 7'h00) begin
      errors++;
      $display("[TB] FAIL lock_before_4th: link_good=%b required 0000000", link_good);
    end
    run_to(384);
    checks++;
    if (link_good !== 7'h01) begin
      errors++;
      $display("[TB] FAIL lock_ch0: link_good=%b required 0000001", link_good);
    end
    run_to(425);
    checks++;
    if (link_good !== 7'h3F) begin
      errors++;
      $display("[TB] FAIL lock_ch6_pending: link_good=%b required 0111111", link_good);
    end
    run_to(426);
    checks++;
    if (link_good !== 7'h7F || link_bad !== 7'h00) begin
      errors++;
      $display("[TB] FAIL lock_all: good=%b bad=%b required 1111111/0000000", link_good, link_bad);
    end
    checks++;
    if (err_count !== '0 || link_had_err !== 7'h00) begin
      errors++;
      $display("[TB] FAIL lock_no_errors: cnt=%h had=%b required 0", err_count, link_had_err);
    end
  endtask

  task automatic test_shift();
    int extra;
    logic [KW-1:0] k645;
    extra = 0;
    k645 = '0;
    ph[0] = 5;
    run_to(511);
    checks++;
    if (err_pulse !== 7'h00) begin
      errors++;
      $display("[TB] FAIL shift_quiet: err_pulse=%b required 0000000", err_pulse);
    end
    run_to(512);
    checks++;
    if (err_pulse !== 7'h01 || err_count[0 +: ECW] !== 16'd1) begin
      errors++;
      $display("[TB] FAIL shift_missing_slot: pulse=%b cnt0=%0d required 0000001/1",
               err_pulse, err_count[0 +: ECW]);
    end
    while (bx <= 700) begin
      step();
      if (err_pulse[0]) extra++;
      if (bx - 1 == 645) k645 = kout[0 +: KW];
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("[TB] FAIL shift_single_pulse: extra pulses=%0d required 0", extra);
    end
    checks++;
    if (err_count[0 +: ECW] !== 16'd1 || link_had_err !== 7'h01 || link_good !== 7'h7F) begin
      errors++;
      $display("[TB] FAIL shift_state: cnt0=%0d had=%b good=%b required 1/0000001/1111111",
               err_count[0 +: ECW], link_had_err, link_good);
    end
    checks++;
    if (k645 !== MARKER) begin
      errors++;
      $display("[TB] FAIL shift_rephase_kout: kout0=%h required %h", k645, MARKER);
    end
  endtask

  task automatic test_delay();
    run_to(705);
    checks++;
    if (dout[DW +: DW] !== din_val(1, 705)) begin
      errors++;
      $display("[TB] FAIL delay0: dout1=%h required %h", dout[DW +: DW], din_val(1, 705));
    end
    dly[1] = 4'd15;
    run_to(706);
    checks++;
    if (dout[DW +: DW] !== din_val(1, 691)) begin
      errors++;
      $display("[TB] FAIL delay_switch: dout1=%h required %h", dout[DW +: DW], din_val(1, 691));
    end
    run_to(710);
    checks++;
    if (dout[DW +: DW] !== din_val(1, 695)) begin
      errors++;
      $display("[TB] FAIL delay15: dout1=%h required %h", dout[DW +: DW], din_val(1, 695));
    end
    checks++;
    if (dout[2*DW +: DW] !== din_val(2, 710)) begin
      errors++;
      $display("[TB] FAIL delay_other_ch: dout2=%h required %h", dout[2*DW +: DW], din_val(2, 710));
    end
  endtask

  task automatic test_drop();
    drop[3] = 3;
    run_to(788);
    checks++;
    if (err_pulse !== 7'h00) begin
      errors++;
      $display("[TB] FAIL drop_quiet: err_pulse=%b required 0000000", err_pulse);
    end
    run_to(789);
    checks++;
    if (err_pulse !== 7'h08) begin
      errors++;
      $display("[TB] FAIL drop_first: err_pulse=%b required 0001000", err_pulse);
    end
    run_to(917);
    checks++;
    if (link_good !== 7'h7F || link_bad !== 7'h00) begin
      errors++;
      $display("[TB] FAIL drop_two: good=%b bad=%b required 1111111/0000000", link_good, link_bad);
    end
    run_to(1045);
    checks++;
    if (link_bad !== 7'h08 || link_good !== 7'h77 || err_count[3*ECW +: ECW] !== 16'd3) begin
      errors++;
      $display("[TB] FAIL drop_bad: bad=%b good=%b cnt3=%0d required 0001000/1110111/3",
               link_bad, link_good, err_count[3*ECW +: ECW]);
    end
    checks++;
    if (dout[3*DW +: DW] !== din_val(3, 1045)) begin
      errors++;
      $display("[TB] FAIL drop_inflight: dout3=%h required %h", dout[3*DW +: DW], din_val(3, 1045));
    end
    run_to(1046);
    checks++;
    if (dout[3*DW +: DW] !== '0 || kout[3*KW +: KW] !== '0) begin
      errors++;
      $display("[TB] FAIL drop_masked: dout3=%h kout3=%h required 0", dout[3*DW +: DW], kout[3*KW +: KW]);
    end
    checks++;
    if (dout[2*DW +: DW] !== din_val(2, 1046) || err_count[0 +: ECW] !== 16'd1 || link_had_err !== 7'h09) begin
      errors++;
      $display("[TB] FAIL drop_isolation: dout2=%h cnt0=%0d had=%b required %h/1/0001001",
               dout[2*DW +: DW], err_count[0 +: ECW], link_had_err, din_val(2, 1046));
    end
    run_to(1180);
    checks++;
    if (link_bad !== 7'h08 || err_count[3*ECW +: ECW] !== 16'd3) begin
      errors++;
      $display("[TB] FAIL drop_sticky: bad=%b cnt3=%0d required 0001000/3", link_bad, err_count[3*ECW +: ECW]);
    end
  endtask

  task automatic test_saturate();
    cont[3] = 1'b1;
    run_to(1280);
    checks++;
    if (err_count[3*ECW +: ECW] !== 16'd103) begin
      errors++;
      $display("[TB] FAIL sat_ramp: cnt3=%0d required 103", err_count[3*ECW +: ECW]);
    end
    run_to(66711);
    checks++;
    if (err_count[3*ECW +: ECW] !== 16'hFFFE) begin
      errors++;
      $display("[TB] FAIL sat_edge: cnt3=%h required fffe", err_count[3*ECW +: ECW]);
    end
    run_to(66712);
    checks++;
    if (err_count[3*ECW +: ECW] !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL sat_reach: cnt3=%h required ffff", err_count[3*ECW +: ECW]);
    end
    run_to(66722);
    checks++;
    if (err_count[3*ECW +: ECW] !== 16'hFFFF || err_pulse[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_hold: cnt3=%h pulse3=%b required ffff/1", err_count[3*ECW +: ECW], err_pulse[3]);
    end
  endtask

  task automatic test_clear();
    err_cnt_clr = 7'h09;
    run_to(66723);
    err_cnt_clr = 7'h00;
    checks++;
    if (err_count[3*ECW +: ECW] !== 16'd1 || err_count[0 +: ECW] !== 16'd0) begin
      errors++;
      $display("[TB] FAIL clr_coincident: cnt3=%0d cnt0=%0d required 1/0",
               err_count[3*ECW +: ECW], err_count[0 +: ECW]);
    end
    run_to(66724);
    checks++;
    if (err_count[3*ECW +: ECW] !== 16'd2) begin
      errors++;
      $display("[TB] FAIL clr_resume: cnt3=%0d required 2", err_count[3*ECW +: ECW]);
    end
  endtask

  task automatic test_resync();
    cont[3] = 1'b0;
    ttc_resync = 1'b1;
    run_to(66725);
    ttc_resync = 1'b0;
    checks++;
    if ({link_good, link_bad, link_had_err, err_pulse} !== '0 || err_count !== '0) begin
      errors++;
      $display("[TB] FAIL resync_clear: good=%b bad=%b had=%b pulse=%b cnt=%h required all 0",
               link_good, link_bad, link_had_err, err_pulse, err_count);
    end
    checks++;
    if (dout[DW +: DW] !== din_val(1, 66710) || dout[2*DW +: DW] !== din_val(2, 66725)) begin
      errors++;
      $display("[TB] FAIL resync_inflight: dout1=%h dout2=%h required %h/%h",
               dout[DW +: DW], dout[2*DW +: DW], din_val(1, 66710), din_val(2, 66725));
    end
    run_to(66726);
    checks++;
    if (dout[2*DW +: DW] !== '0 || dout[DW +: DW] !== din_val(1, 66711)) begin
      errors++;
      $display("[TB] FAIL resync_after: dout2=%h dout1=%h required 0/%h",
               dout[2*DW +: DW], dout[DW +: DW], din_val(1, 66711));
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    bx          = 0;
    reset       = 1'b1;
    ttc_resync  = 1'b0;
    err_cnt_clr = '0;
    delay       = '0;
    din         = '0;
    kin         = '0;
    for (int c = 0; c < NCH; c++) begin
      ph[c]   = 7 * c;
      on[c]   = 1'b0;
      drop[c] = 0;
      cont[c] = 1'b0;
      dly[c]  = 4'd0;
    end

    test_reset();
    test_lock();
    test_shift();
    test_delay();
    test_drop();
    test_saturate();
    test_clear();
    test_resync();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
